segment_persist_ctrl: RTL and testbench

//   Drives the segments[x][y][z] array read by the LCD segment renderer. Collects the CPU's

---
 rtl/segment_persist_ctrl.sv | 128 ++++++++++++
 tb/tb_segment_persist_ctrl.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/segment_persist_ctrl.sv
// LCD segment persistence controller: captures multiplexed segment strobes into a
// per-frame hit buffer and, once per vblank, sweeps every segment applying decay.
module segment_persist_ctrl #(
  parameter int MAX_X_SEGMENT = 9,
  parameter int MAX_Y_SEGMENT = 16,
  parameter int MAX_Z_SEGMENT = 4,
  parameter int DECAY_FRAMES  = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     seg_wr,
  input  logic [3:0]               seg_x,
  input  logic [1:0]               seg_h,
  input  logic [15:0]              seg_data,
  input  logic                     vblank_int,
  output logic [MAX_Z_SEGMENT-1:0] segments [MAX_X_SEGMENT][MAX_Y_SEGMENT],
  output logic                     busy,
  output logic                     frame_done,
  output logic                     sweep_overrun
);

  localparam int          N     = MAX_X_SEGMENT * MAX_Y_SEGMENT * MAX_Z_SEGMENT;
  localparam int          IW    = 10;
  localparam logic [IW-1:0] LAST  = IW'(N - 1);
  localparam logic [3:0]  DECAY = 4'(DECAY_FRAMES);

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic            vblank_int_d;
  logic            vblank_rise;
  logic [IW-1:0]   idx;
  logic [N-1:0]    hit;
  logic [N-1:0]    wr_mask;
  logic [N-1:0]    clr_mask;
  logic [N-1:0]    lit;
  logic [3:0]      cnt [N];
  logic            start;
  logic            step;
  logic            last;

  assign vblank_rise = vblank_int & ~vblank_int_d;

  // Out-of-range seg_x / seg_h simply match no element, so such writes are dropped.
  for (genvar gx = 0; gx < MAX_X_SEGMENT; gx++) begin : g_x
    for (genvar gy = 0; gy < MAX_Y_SEGMENT; gy++) begin : g_y
      for (genvar gz = 0; gz < MAX_Z_SEGMENT; gz++) begin : g_z
        localparam int I = (gx * MAX_Y_SEGMENT + gy) * MAX_Z_SEGMENT + gz;
        assign wr_mask[I]          = seg_wr && (seg_x == 4'(gx)) && (seg_h == 2'(gz))
                                     && seg_data[gy];
        assign segments[gx][gy][gz] = lit[I];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    step    = 1'b0;
    last    = 1'b0;
    case (state_q)
      IDLE: begin
        if (vblank_rise) begin
          state_d = SWEEP;
          start   = 1'b1;
        end
      end
      SWEEP: begin
        step = 1'b1;
        if (idx == LAST) begin
          last    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    clr_mask = '0;
    if (step) clr_mask[idx] = 1'b1;
  end

  // vblank_int_d is a plain edge-detect delay and keeps tracking through reset.
  always_ff @(posedge clk) begin
    vblank_int_d <= vblank_int;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= IDLE;
      idx           <= '0;
      hit           <= '0;
      lit           <= '0;
      busy          <= 1'b0;
      frame_done    <= 1'b0;
      sweep_overrun <= 1'b0;
      for (int i = 0; i < N; i++) cnt[i] <= '0;
    end else begin
      state_q    <= state_d;
      frame_done <= last;
      // A write landing on the element being swept survives into the next frame.
      hit        <= (hit & ~clr_mask) | wr_mask;
      if (start) begin
        idx  <= '0;
        busy <= 1'b1;
      end
      if (vblank_rise && (state_q == SWEEP)) sweep_overrun <= 1'b1;
      if (step) begin
        if (hit[idx]) begin
          cnt[idx] <= DECAY;
          lit[idx] <= 1'b1;
        end else if (cnt[idx] != 4'd0) begin
          cnt[idx] <= cnt[idx] - 4'd1;
          lit[idx] <= (cnt[idx] != 4'd1);
        end else begin
          lit[idx] <= 1'b0;
        end
        if (last) busy <= 1'b0;
        else      idx  <= idx + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_segment_persist_ctrl.sv
// Bench for segment_persist_ctrl: directed frames with hand-built expected segment maps
// checked by a frame_done-driven monitor against a queue.
module tb_segment_persist_ctrl;

  localparam int MX = 9;
  localparam int MY = 16;
  localparam int MZ = 4;
  localparam int N  = MX * MY * MZ;
  localparam int LAT = N + 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          seg_wr;
  logic [3:0]    seg_x;
  logic [1:0]    seg_h;
  logic [15:0]   seg_data;
  logic          vblank_int;
  logic [MZ-1:0] segments [MX][MY];
  logic          busy;
  logic          frame_done;
  logic          sweep_overrun;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  logic [N-1:0] exp_q[$];

  segment_persist_ctrl #(
    .MAX_X_SEGMENT(MX), .MAX_Y_SEGMENT(MY), .MAX_Z_SEGMENT(MZ), .DECAY_FRAMES(2)
  ) dut (
    .clk(clk), .reset(reset), .seg_wr(seg_wr), .seg_x(seg_x), .seg_h(seg_h),
    .seg_data(seg_data), .vblank_int(vblank_int), .segments(segments), .busy(busy),
    .frame_done(frame_done), .sweep_overrun(sweep_overrun)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int idx_of(input int x, input int y, input int z);
    return (x * MY + y) * MZ + z;
  endfunction

  function automatic logic [N-1:0] flat_seg();
    logic [N-1:0] v;
    v = '0;
    for (int x = 0; x < MX; x++)
      for (int y = 0; y < MY; y++)
        for (int z = 0; z < MZ; z++)
          v[idx_of(x, y, z)] = segments[x][y][z];
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    if (reset === 1'b1 && frame_done === 1'b1) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_frame_done at cycle %0d", cyc);
      end else begin
        logic [N-1:0] e, a;
        e = exp_q.pop_front();
        a = flat_seg();
        if (a === e) n_pass++;
        else $display("FAIL frame_segments: got %h expected %h", a, e);
      end
    end
  end

  // driver tasks
  task automatic do_reset();
    reset = 1'b0; seg_wr = 1'b0; vblank_int = 1'b0;
    seg_x = '0; seg_h = '0; seg_data = '0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic write_seg(input logic [3:0] x, input logic [1:0] h, input logic [15:0] d);
    seg_wr = 1'b1; seg_x = x; seg_h = h; seg_data = d;
    @(negedge clk);
    seg_wr = 1'b0; seg_data = '0;
  endtask

  // One full frame; optional write timed to land when sweep index wr_at is processed,
  // optional extra vblank pulse vb_at cycles after the starting edge.
  task automatic run_frame(input string name, input logic [N-1:0] exp, input int wr_at,
                           input logic [3:0] wx, input logic [1:0] wh, input logic [15:0] wd,
                           input int vb_at);
    int start_cyc, waited;
    exp_q.push_back(exp);
    vblank_int = 1'b1;
    start_cyc  = cyc;
    @(negedge clk);
    check({name, "_busy_rise"}, 32'(busy), 32'd1);
    waited = 0;
    while (frame_done !== 1'b1 && waited < 2000) begin
      if (wr_at >= 0 && cyc == start_cyc + 1 + wr_at) begin
        seg_wr = 1'b1; seg_x = wx; seg_h = wh; seg_data = wd;
      end else begin
        seg_wr = 1'b0; seg_data = '0;
      end
      vblank_int = (vb_at >= 0 && cyc == start_cyc + vb_at);
      @(negedge clk);
      waited++;
    end
    seg_wr = 1'b0; vblank_int = 1'b0;
    if (frame_done !== 1'b1) begin
      check({name, "_timeout"}, 32'(waited), 32'd0);
      void'(exp_q.pop_back());
    end else begin
      check({name, "_latency"}, 32'(cyc - start_cyc), 32'(LAT));
    end
    @(negedge clk);
    check({name, "_done_pulse"}, 32'(frame_done), 32'd0);
    check({name, "_busy_fall"}, 32'(busy), 32'd0);
  endtask

  initial begin
    logic [N-1:0] e;
    int start_cyc;

    do_reset();
    check("reset_segments", 32'(flat_seg() != '0), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(frame_done), 32'd0);
    check("reset_overrun", 32'(sweep_overrun), 32'd0);

    // single hit at (0,0,0)
    write_seg(4'd0, 2'd0, 16'h0001);
    e = '0; e[idx_of(0, 0, 0)] = 1'b1;
    run_frame("t1", e, -1, 0, 0, 0, -1);

    // decay over three frames for (3,5,2)
    do_reset();
    write_seg(4'd3, 2'd2, 16'h0020);
    e = '0; e[idx_of(3, 5, 2)] = 1'b1;
    run_frame("t2_f1", e, -1, 0, 0, 0, -1);
    run_frame("t2_f2", e, -1, 0, 0, 0, -1);
    run_frame("t2_f3", '0, -1, 0, 0, 0, -1);

    // write coinciding with the sweep of (2,7,1)
    do_reset();
    run_frame("t3_f1", '0, idx_of(2, 7, 1), 4'd2, 2'd1, 16'h0080, -1);
    e = '0; e[idx_of(2, 7, 1)] = 1'b1;
    run_frame("t3_f2", e, -1, 0, 0, 0, -1);

    // ignored writes
    do_reset();
    write_seg(4'd9, 2'd0, 16'hFFFF);
    write_seg(4'd15, 2'd3, 16'hFFFF);
    write_seg(4'd4, 2'd1, 16'h0000);
    run_frame("t4_f1", '0, -1, 0, 0, 0, -1);
    run_frame("t4_f2", '0, -1, 0, 0, 0, -1);

    // vblank during sweep
    do_reset();
    write_seg(4'd1, 2'd1, 16'h0003);
    e = '0; e[idx_of(1, 0, 1)] = 1'b1; e[idx_of(1, 1, 1)] = 1'b1;
    run_frame("t5_f1", e, -1, 0, 0, 0, 100);
    check("t5_overrun_set", 32'(sweep_overrun), 32'd1);
    run_frame("t5_f2", e, -1, 0, 0, 0, -1);
    check("t5_overrun_sticky", 32'(sweep_overrun), 32'd1);
    do_reset();
    check("t5_overrun_cleared", 32'(sweep_overrun), 32'd0);

    // reset mid-sweep at idx 200
    write_seg(4'd0, 2'd0, 16'hFFFF);
    e = '0;
    for (int y = 0; y < MY; y++) e[idx_of(0, y, 0)] = 1'b1;
    run_frame("t6_f1", e, -1, 0, 0, 0, -1);
    vblank_int = 1'b1;
    start_cyc  = cyc;
    @(negedge clk);
    vblank_int = 1'b0;
    while (cyc < start_cyc + 201) @(negedge clk);
    check("t6_busy_mid", 32'(busy), 32'd1);
    reset = 1'b0;
    @(negedge clk);
    check("t6_abort_segments", 32'(flat_seg() != '0), 32'd0);
    check("t6_abort_busy", 32'(busy), 32'd0);
    check("t6_abort_done", 32'(frame_done), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    write_seg(4'd0, 2'd0, 16'h0001);
    e = '0; e[idx_of(0, 0, 0)] = 1'b1;
    run_frame("t6_f2", e, -1, 0, 0, 0, -1);

    repeat (3) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
